mem_copy_dma: RTL
=================

Name: mem_copy_dma

Overview:
- Bus-master copy engine that sits directly upstream of the 256x8 `memory` block.
- Drives memory's `rd`/`wr`/`addr`/`data` interface to copy a block of bytes from a source address range to a destination range.
- Replaces hand-sequenced write/read bursts for block moves (e.g. loading a frame buffer from a staging area).
- A single start pulse launches a copy; a one-cycle done pulse reports completion.

Parameters:
- RD_LATENCY, 1: cycles `mem_rd` is held per read; data is sampled at the rising edge ending the last held cycle (1..4 legal).

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  copy request, sampled only when busy=0
- src  in  8  source start address, captured with start
- dst  in  8  destination start address, captured with start
- len  in  8  byte count, captured with start; 0 = no-op
- busy  out  1  high while a copy is in progress
- done  out  1  one-cycle pulse after the last write (or after a len=0 request)
- mem_rd  out  1  memory read strobe
- mem_wr  out  1  memory write strobe
- mem_addr  out  8  memory address
- mem_data  inout  8  memory data bus; driven only while mem_wr=1, else 8'bz

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
  - Ports are named clk and reset.
  - On a reset edge: busy=0, done=0, mem_rd=0, mem_wr=0, mem_addr=8'h00, mem_data released (Z), internal counters cleared, state IDLE.
- Registered outputs: all outputs are registered except the tristate enable.
  - The tristate enable is exactly mem_wr.
- States: IDLE, READ, WRITE.
- IDLE:
  - Idle levels: mem_rd=0, mem_wr=0, mem_addr=0.
  - On an edge with start=1 and len!=0: capture src/dst/len, clear the byte index i, go to READ, busy=1.
  - On an edge with start=1 and len=0: stay IDLE; done=1 for the following cycle; no bus activity.
- READ:
  - Outputs: mem_rd=1, mem_wr=0, mem_addr=src+i.
  - Hold for RD_LATENCY cycles.
  - At the edge ending the last held cycle, latch mem_data into the byte buffer, then go to WRITE.
- WRITE (one cycle):
  - Outputs: mem_wr=1, mem_rd=0, mem_addr=dst+i, mem_data=byte buffer.
  - At the edge ending the cycle: i=i+1.
  - If i+1==len: go to IDLE with busy=0 and done=1 for one cycle, with mem_addr=0.
  - Otherwise go to READ.
- Invariant: mem_rd and mem_wr are never both 1.
- Address arithmetic: src+i and dst+i are 8-bit and wrap modulo 256.
  - i is 8 bits wide; len ranges 1..255.
- Timing: with start sampled at edge E0, the copy occupies N*(RD_LATENCY+1) cycles.
  - done is high in the cycle following edge E0+N*(RD_LATENCY+1).
  - busy is high from E0 through that edge.
- start while busy=1 is ignored; no queueing.
- start during the done cycle is accepted (busy is already 0).
- Overlapping ranges: the copy is strictly ascending and byte-by-byte; each read completes before its write.
  - Consequence: dst=src+1 propagates the first byte. This is defined behaviour, not an error.
- Reset mid-copy: strobes drop in the cycle after the reset edge and the bus is released.
  - Bytes already written remain; no done pulse is issued.
  - The next start is accepted normally.

Test Plan:
- Basic copy: preload mem[10..13]=11,22,33,44; start src=10 dst=80 len=4 (RD_LATENCY=1).
  - mem[80..83]=11,22,33,44.
  - Exactly 4 rd and 4 wr strobes, alternating.
  - done pulses for one cycle, 9 cycles after the start cycle.
  - busy is high for 8 cycles.
- Zero length: start len=0 → done=1 in the next cycle; mem_rd/mem_wr stay 0; busy stays 0.
- Wrap-around: preload mem[FE,FF,00,01]=A1,A2,A3,A4; start src=FE dst=02 len=4.
  - Read addresses FE,FF,00,01.
  - mem[02..05]=A1..A4.
- Ignored start: during the copy of the basic test, pulse start with src=00 dst=00 len=1.
  - No extra strobes.
  - The result is identical to the basic test.
  - There is only one done pulse.
- Reset mid-copy: start src=10 dst=80 len=4; assert reset after the 2nd write.
  - mem[80..81] are written; mem[82..83] are unchanged.
  - busy=0, done never pulses, and mem_data is Z.
  - A subsequent start completes correctly.
- Overlap: mem[20]=5A; start src=20 dst=21 len=3 → mem[21..23]=5A,5A,5A.

Source files
------------

// File: rtl/mem_copy_dma.sv
// rtl/mem_copy_dma.sv - bus-master block copy engine driving a 256x8 memory
module mem_copy_dma #(
    parameter int RD_LATENCY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] src,
    input  logic [7:0] dst,
    input  logic [7:0] len,
    output logic       busy,
    output logic       done,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic [7:0] mem_addr,
    inout  wire  [7:0] mem_data
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    localparam logic [1:0] LAT_LAST = 2'(RD_LATENCY - 1);

    logic [1:0] state;
    logic [1:0] lat_cnt;
    logic [7:0] src_q;
    logic [7:0] dst_q;
    logic [7:0] len_q;
    logic [7:0] idx;
    logic [7:0] byte_buf;
    logic [7:0] idx_next;

    assign idx_next = idx + 8'd1;

    // The write strobe is the only bus-drive enable, so a read never collides.
    assign mem_data = mem_wr ? byte_buf : 8'bz;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            lat_cnt  <= 2'd0;
            src_q    <= 8'h00;
            dst_q    <= 8'h00;
            len_q    <= 8'h00;
            idx      <= 8'h00;
            byte_buf <= 8'h00;
            busy     <= 1'b0;
            done     <= 1'b0;
            mem_rd   <= 1'b0;
            mem_wr   <= 1'b0;
            mem_addr <= 8'h00;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (len == 8'h00) begin
                            done <= 1'b1;
                        end else begin
                            src_q    <= src;
                            dst_q    <= dst;
                            len_q    <= len;
                            idx      <= 8'h00;
                            lat_cnt  <= 2'd0;
                            state    <= S_READ;
                            busy     <= 1'b1;
                            mem_rd   <= 1'b1;
                            mem_addr <= src;
                        end
                    end
                end
                S_READ: begin
                    if (lat_cnt == LAT_LAST) begin
                        byte_buf <= mem_data;
                        state    <= S_WRITE;
                        mem_rd   <= 1'b0;
                        mem_wr   <= 1'b1;
                        mem_addr <= dst_q + idx;
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                S_WRITE: begin
                    idx     <= idx_next;
                    mem_wr  <= 1'b0;
                    lat_cnt <= 2'd0;
                    if (idx_next == len_q) begin
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        mem_addr <= 8'h00;
                    end else begin
                        state    <= S_READ;
                        mem_rd   <= 1'b1;
                        mem_addr <= src_q + idx_next;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    busy     <= 1'b0;
                    mem_rd   <= 1'b0;
                    mem_wr   <= 1'b0;
                    mem_addr <= 8'h00;
                end
            endcase
        end
    end

endmodule
